// File: rtl/mycpu_pkg.sv
// Shared types and encodings for the multi-cycle CPU control unit.
// Opcode low nibble doubles as the ALU function select for ALU/LDI/ADI.
package mycpu_pkg;

  localparam int OPC_W = 7;

  typedef enum logic [OPC_W-1:0] {
    OP_MOVA = 7'h00,
    OP_INC  = 7'h01,
    OP_ADD  = 7'h02,
    OP_SUB  = 7'h05,
    OP_DEC  = 7'h06,
    OP_AND  = 7'h08,
    OP_OR   = 7'h09,
    OP_XOR  = 7'h0A,
    OP_NOT  = 7'h0B,
    OP_MOVB = 7'h0C,
    OP_SHR  = 7'h0D,
    OP_SHL  = 7'h0E,
    OP_LD   = 7'h10,
    OP_IOR  = 7'h11,
    OP_ST   = 7'h20,
    OP_IOW  = 7'h21,
    OP_ADI  = 7'h42,
    OP_LDI  = 7'h4C,
    OP_NOP  = 7'h50,
    OP_BRZ  = 7'h60,
    OP_BRN  = 7'h61,
    OP_JMP  = 7'h70,
    OP_HAL  = 7'h7F
  } opcode_t;

  typedef enum logic [1:0] {
    ST_RST = 2'd0,
    ST_INF = 2'd1,
    ST_EX  = 2'd2,
    ST_HLT = 2'd3
  } cuws_state_t;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_JMP  = 2'b11;

  localparam logic [1:0] MD_ALU = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_IO  = 2'b10;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_TMO  = 2'b01;
  localparam logic [1:0] ERR_ILL  = 2'b10;

  function automatic logic is_alu(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_MOVA, OP_INC, OP_ADD, OP_SUB, OP_DEC, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_MOVB, OP_SHR, OP_SHL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_xfer(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_LD, OP_ST, OP_IOR, OP_IOW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_LDI, OP_ADI, OP_NOP, OP_BRZ, OP_BRN, OP_JMP, OP_HAL: return 1'b1;
      default: return is_alu(opc) | is_xfer(opc);
    endcase
  endfunction

endpackage

// File: rtl/cu_ws_wdog.sv
// Wait-state counter: counts cycles a transfer is pending without ready and
// flags expiry when the count has reached WAIT_MAX and ready is still low.
module cu_ws_wdog #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = $clog2(WAIT_MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  input  logic ready_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_max;

  assign at_max    = (cnt_q == CNT_W'(WAIT_MAX));
  assign expired_o = count_i & ~ready_i & at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && !ready_i && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cu_ws.sv
// Multi-cycle CPU control unit: fetch/execute sequencing with memory/IO
// wait states, bus timeout and halt/resume.
module cu_ws
  import mycpu_pkg::*;
#(
  parameter int OPC_W    = 7,
  parameter int RA_W     = 3,
  parameter int RS_W     = 4,
  parameter int WAIT_MAX = 15,
  parameter int IW       = OPC_W + 3 * RA_W,
  parameter int CNT_W    = $clog2(WAIT_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IW-1:0]     ins_in,
  input  logic              z_in,
  input  logic              n_in,
  input  logic              mem_ready_in,
  input  logic              resume_in,
  output logic              il_out,
  output logic [1:0]        ps_out,
  output logic              rw_out,
  output logic [3*RS_W-1:0] rs_out,
  output logic              mm_out,
  output logic [1:0]        md_out,
  output logic              mb_out,
  output logic [3:0]        fs_out,
  output logic              wen_out,
  output logic              iom_out,
  output logic              mem_req_out,
  output logic              halted_out,
  output logic [1:0]        err_out
);

  cuws_state_t      state_q, state_d;
  logic [1:0]       err_q, err_d;
  logic [OPC_W-1:0] opc;
  logic [RS_W-1:0]  dr_x, sa_x, sb_x;
  logic             expired, wd_clear;
  logic             op_xfer, op_legal;

  assign opc      = ins_in[IW-1 -: OPC_W];
  assign dr_x     = RS_W'(ins_in[3*RA_W-1 -: RA_W]);
  assign sa_x     = RS_W'(ins_in[2*RA_W-1 -: RA_W]);
  assign sb_x     = RS_W'(ins_in[RA_W-1:0]);
  assign op_xfer  = is_xfer(opc);
  assign op_legal = is_legal(opc);

  // Any state change is an entry into a new phase, so the count restarts.
  assign wd_clear = (state_d != state_q);

  cu_ws_wdog #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (wd_clear),
    .count_i   (mem_req_out),
    .ready_i   (mem_ready_in),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_RST: state_d = ST_INF;
      ST_INF: begin
        if (mem_ready_in) begin
          state_d = ST_EX;
        end else if (expired) begin
          state_d = ST_HLT;
          err_d   = ERR_TMO;
        end
      end
      ST_EX: begin
        if (!op_legal) begin
          state_d = ST_HLT;
          err_d   = ERR_ILL;
        end else if (opc == OP_HAL) begin
          state_d = ST_HLT;
        end else if (op_xfer) begin
          if (mem_ready_in) begin
            state_d = ST_INF;
          end else if (expired) begin
            state_d = ST_HLT;
            err_d   = ERR_TMO;
          end
        end else begin
          state_d = ST_INF;
        end
      end
      ST_HLT: begin
        if (resume_in) begin
          state_d = ST_INF;
          err_d   = ERR_NONE;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    il_out      = 1'b0;
    ps_out      = PS_HOLD;
    rw_out      = 1'b0;
    rs_out      = '0;
    mm_out      = 1'b0;
    md_out      = MD_ALU;
    mb_out      = 1'b0;
    fs_out      = 4'b0000;
    wen_out     = 1'b1;
    iom_out     = 1'b0;
    mem_req_out = 1'b0;
    halted_out  = 1'b0;
    err_out     = err_q;
    case (state_q)
      ST_INF: begin
        mem_req_out = 1'b1;
        mm_out      = 1'b1;
        il_out      = mem_ready_in;
      end
      ST_EX: begin
        rs_out = {dr_x, sa_x, sb_x};
        if (op_xfer) begin
          mem_req_out = 1'b1;
          iom_out     = (opc == OP_IOR) || (opc == OP_IOW);
          wen_out     = !((opc == OP_ST) || (opc == OP_IOW));
          if (opc == OP_LD)  md_out = MD_MEM;
          if (opc == OP_IOR) md_out = MD_IO;
          if (mem_ready_in) begin
            ps_out = PS_INC;
            rw_out = (opc == OP_LD) || (opc == OP_IOR);
          end
        end else if (op_legal && opc != OP_HAL) begin
          fs_out = opc[3:0];
          rw_out = is_alu(opc) || (opc == OP_LDI) || (opc == OP_ADI);
          mb_out = (opc == OP_LDI) || (opc == OP_ADI);
          ps_out = PS_INC;
          if (opc == OP_BRZ) begin
            ps_out = z_in ? PS_BR : PS_INC;
            fs_out = 4'b0000;
          end else if (opc == OP_BRN) begin
            ps_out = n_in ? PS_BR : PS_INC;
            fs_out = 4'b0000;
          end else if (opc == OP_JMP) begin
            ps_out = PS_JMP;
          end
        end
      end
      ST_HLT: halted_out = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cu_ws.sv
// Directed bench for cu_ws: fetch/execute, wait states, branches, timeout,
// ready at the timeout boundary, illegal opcode and mid-transfer reset.
module tb_cu_ws;

  localparam int WAIT_MAX = 15;
  localparam int IW       = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] ins_in;
  logic          z_in, n_in, mem_ready_in, resume_in;
  logic          il_out, rw_out, mm_out, mb_out, wen_out, iom_out;
  logic          mem_req_out, halted_out;
  logic [1:0]    ps_out, md_out, err_out;
  logic [11:0]   rs_out;
  logic [3:0]    fs_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cu_ws dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ins_in       (ins_in),
    .z_in         (z_in),
    .n_in         (n_in),
    .mem_ready_in (mem_ready_in),
    .resume_in    (resume_in),
    .il_out       (il_out),
    .ps_out       (ps_out),
    .rw_out       (rw_out),
    .rs_out       (rs_out),
    .mm_out       (mm_out),
    .md_out       (md_out),
    .mb_out       (mb_out),
    .fs_out       (fs_out),
    .wen_out      (wen_out),
    .iom_out      (iom_out),
    .mem_req_out  (mem_req_out),
    .halted_out   (halted_out),
    .err_out      (err_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 2 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] mk_ins(input logic [6:0] opc, input logic [2:0] dr,
                                         input logic [2:0] sa, input logic [2:0] sb);
    return {opc, dr, sa, sb};
  endfunction

  // Fetch with immediate ready: checks the INF cycle and steps into EX.
  task automatic fetch(input logic [15:0] ins, input string tag);
    ins_in       = ins;
    mem_ready_in = 1'b1;
    #1;
    check({tag, "_inf_il"}, il_out, 1'b1);
    check({tag, "_inf_mm"}, mm_out, 1'b1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; ins_in = '0; z_in = 1'b0; n_in = 1'b0;
    mem_ready_in = 1'b1; resume_in = 1'b0;
    #12;
    check("rst_wen", wen_out, 1'b1);
    check("rst_req", mem_req_out, 1'b0);
    check("rst_halt", halted_out, 1'b0);
    check("rst_err", err_out, 2'b00);
    rst_n = 1'b1;
    #1;
    check("rst_state_req", mem_req_out, 1'b0);
    tick();

    // ADD r3 <- r1 + r2
    fetch(mk_ins(7'h02, 3'd3, 3'd1, 3'd2), "add");
    check("add_rw", rw_out, 1'b1);
    check("add_ps", ps_out, 2'b01);
    check("add_fs", fs_out, 4'h2);
    check("add_rs", rs_out, 12'h312);
    check("add_req", mem_req_out, 1'b0);
    tick();

    // LD with three wait cycles
    fetch(mk_ins(7'h10, 3'd5, 3'd1, 3'd0), "ld");
    mem_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ld_wait_req", mem_req_out, 1'b1);
      check("ld_wait_ps", ps_out, 2'b00);
      check("ld_wait_rw", rw_out, 1'b0);
      check("ld_wait_mm", mm_out, 1'b0);
      tick();
    end
    mem_ready_in = 1'b1;
    #1;
    check("ld_rdy_rw", rw_out, 1'b1);
    check("ld_rdy_md", md_out, 2'b01);
    check("ld_rdy_ps", ps_out, 2'b01);
    check("ld_rdy_rs", rs_out, 12'h510);
    tick();
    check("ld_back_inf", mem_req_out & mm_out, 1'b1);

    // BRZ taken then not taken
    z_in = 1'b1;
    fetch(mk_ins(7'h60, 3'd0, 3'd4, 3'd0), "brz1");
    check("brz1_ps", ps_out, 2'b10);
    check("brz1_fs", fs_out, 4'h0);
    check("brz1_rw", rw_out, 1'b0);
    tick();
    z_in = 1'b0;
    fetch(mk_ins(7'h60, 3'd0, 3'd4, 3'd0), "brz0");
    check("brz0_ps", ps_out, 2'b01);
    check("brz0_rw", rw_out, 1'b0);
    tick();

    // JMP and LDI
    fetch(mk_ins(7'h70, 3'd0, 3'd6, 3'd0), "jmp");
    check("jmp_ps", ps_out, 2'b11);
    tick();
    fetch(mk_ins(7'h4C, 3'd7, 3'd0, 3'd5), "ldi");
    check("ldi_mb", mb_out, 1'b1);
    check("ldi_rw", rw_out, 1'b1);
    check("ldi_fs", fs_out, 4'hC);
    tick();

    // ST that never completes: WAIT_MAX+1 request cycles then timeout halt
    fetch(mk_ins(7'h20, 3'd0, 3'd2, 3'd3), "st");
    mem_ready_in = 1'b0;
    for (int i = 0; i <= WAIT_MAX; i++) begin
      #1;
      check("st_wen", wen_out, 1'b0);
      check("st_req", mem_req_out, 1'b1);
      check("st_not_halted", halted_out, 1'b0);
      tick();
    end
    #1;
    check("tmo_halted", halted_out, 1'b1);
    check("tmo_err", err_out, 2'b01);
    check("tmo_req", mem_req_out, 1'b0);
    check("tmo_wen", wen_out, 1'b1);
    tick();
    check("tmo_still_halted", halted_out, 1'b1);
    resume_in = 1'b1;
    tick();
    resume_in = 1'b0;
    #1;
    check("res_err", err_out, 2'b00);
    check("res_halted", halted_out, 1'b0);
    check("res_inf", mem_req_out & mm_out, 1'b1);

    // IOR with ready exactly when the count sits at WAIT_MAX
    fetch(mk_ins(7'h11, 3'd2, 3'd0, 3'd0), "ior");
    mem_ready_in = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) tick();
    mem_ready_in = 1'b1;
    #1;
    check("ior_rw", rw_out, 1'b1);
    check("ior_md", md_out, 2'b10);
    check("ior_iom", iom_out, 1'b1);
    check("ior_ps", ps_out, 2'b01);
    tick();
    check("ior_err", err_out, 2'b00);
    check("ior_halted", halted_out, 1'b0);

    // Illegal opcode
    fetch(mk_ins(7'h33, 3'd0, 3'd0, 3'd0), "ill");
    check("ill_ps", ps_out, 2'b00);
    check("ill_rw", rw_out, 1'b0);
    tick();
    check("ill_halted", halted_out, 1'b1);
    check("ill_err", err_out, 2'b10);
    resume_in = 1'b1;
    tick();
    resume_in = 1'b0;
    check("ill_res_err", err_out, 2'b00);

    // HAL halts without error
    fetch(mk_ins(7'h7F, 3'd0, 3'd0, 3'd0), "hal");
    check("hal_ps", ps_out, 2'b00);
    tick();
    check("hal_halted", halted_out, 1'b1);
    check("hal_err", err_out, 2'b00);
    resume_in = 1'b1;
    tick();
    resume_in = 1'b0;

    // Reset in the middle of an IOW transfer
    fetch(mk_ins(7'h21, 3'd0, 3'd1, 3'd4), "iow");
    mem_ready_in = 1'b0;
    tick();
    check("iow_wen", wen_out, 1'b0);
    check("iow_iom", iom_out, 1'b1);
    rst_n = 1'b0;
    #1;
    check("iow_rst_wen", wen_out, 1'b1);
    check("iow_rst_req", mem_req_out, 1'b0);
    check("iow_rst_iom", iom_out, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_req", mem_req_out, 1'b0);
    tick();
    check("post_rst_inf", mem_req_out & mm_out, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
